// File: rtl/bidir_pio_irq.sv
// Memory-mapped bidirectional PIO with per-pin edge capture and a level interrupt.
// Reads are registered (1 cycle); pin edges reach edgecap 2 cycles after first sampling.
module bidir_pio_irq #(
  parameter int               WIDTH     = 8,
  parameter int               EDGE_TYPE = 0,
  parameter logic [WIDTH-1:0] RESET_OUT = '0,
  parameter logic [WIDTH-1:0] RESET_DIR = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  inout  wire  [WIDTH-1:0] bidir_port
);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  logic [WIDTH-1:0] data_out, dir, irqmask, edgecap;
  logic [WIDTH-1:0] s1, s2, s3;
  logic [WIDTH-1:0] edge_det, cap_set, cap_clr, wd;
  logic [1:0]       arm_cnt;
  logic             wr, armed;
  logic [31:0]      rd_mux;
  logic             unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign armed     = (arm_cnt == 2'd3);
  assign unused_wd = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign bidir_port[i] = dir[i] ? data_out[i] : 1'bz;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_OUT;
      dir      <= RESET_DIR;
      irqmask  <= '0;
    end else if (wr) begin
      case (address)
        ADDR_DATA:    data_out <= wd;
        ADDR_DIR:     dir      <= wd;
        ADDR_IRQMASK: irqmask  <= wd;
        ADDR_OUTSET:  data_out <= data_out | wd;
        ADDR_OUTCLR:  data_out <= data_out & ~wd;
        default: ;
      endcase
    end
  end

  // s3 holds the previous synchronised sample so edges compare s2 against it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1      <= '0;
      s2      <= '0;
      s3      <= '0;
      arm_cnt <= 2'd0;
    end else begin
      s1 <= bidir_port;
      s2 <= s1;
      s3 <= s2;
      if (!armed) arm_cnt <= arm_cnt + 2'd1;
    end
  end

  always_comb begin
    edge_det = s2 & ~s3;
    case (EDGE_TYPE)
      1:       edge_det = ~s2 & s3;
      2:       edge_det = s2 ^ s3;
      default: edge_det = s2 & ~s3;
    endcase
  end

  assign cap_set = armed ? edge_det : '0;
  assign cap_clr = (wr && address == ADDR_EDGECAP) ? wd : '0;

  // Set is applied after clear so a coincident capture is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edgecap <= '0;
    else          edgecap <= (edgecap & ~cap_clr) | cap_set;
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = s2;
      ADDR_DIR:     rd_mux[WIDTH-1:0] = dir;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecap;
      ADDR_OUTSET,
      ADDR_OUTCLR:  rd_mux[WIDTH-1:0] = data_out;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign irq = |(edgecap & irqmask);

endmodule
